// File: rtl/alu_lifo_if.sv
// Bus bundle between the calculator board/ALU side and the LIFO sequencing
// controller.
//   master : drives the button levels, live operands/opcode and the ALU result F;
//            observes the registered ALU operands and the display/status outputs.
//   slave  : the controller; consumes the inputs and drives everything else.
interface alu_lifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          execute;
  logic          read;
  logic [2:0]    A;
  logic [2:0]    B;
  logic [2:0]    opcodein;
  logic [5:0]    F;
  logic [2:0]    alu_a;
  logic [2:0]    alu_b;
  logic [2:0]    alu_op;
  logic [5:0]    result_out;
  logic [2:0]    opcode_out;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;
  logic          ovf_err;
  logic          udf_err;

  modport master (
    output execute, read, A, B, opcodein, F,
    input  alu_a, alu_b, alu_op, result_out, opcode_out, out_valid,
           count, full, empty, busy, ovf_err, udf_err
  );

  modport slave (
    input  execute, read, A, B, opcodein, F,
    output alu_a, alu_b, alu_op, result_out, opcode_out, out_valid,
           count, full, empty, busy, ovf_err, udf_err
  );
endinterface

// File: rtl/alu_lifo_ctrl.sv
// Sequencing controller for the calculator datapath.
// Turns execute/read level inputs into single-cycle events, launches one ALU
// operation per execute, pushes {opcode, F} onto an internal LIFO and pops the
// top entry to the display outputs on read.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : alu_lifo_if slave modport (buttons, operands, F in; ALU operands,
//              popped result/opcode, out_valid, count/full/empty, busy,
//              sticky ovf_err/udf_err out)
module alu_lifo_ctrl #(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1
) (
  input logic       clk,
  input logic       reset_n,
  alu_lifo_if.slave bus
);
  localparam int            CW        = $clog2(DEPTH + 1);
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [3:0]    WAIT_INIT = 4'(ALU_LAT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_n;
  logic          exe_q, rd_q;
  logic          exe_ev, rd_ev;
  logic [3:0]    wcnt, wcnt_n;
  logic [CW-1:0] count, count_n;
  logic          rd_pend, rd_pend_n;
  logic [2:0]    alu_a, alu_a_n;
  logic [2:0]    alu_b, alu_b_n;
  logic [2:0]    alu_op, alu_op_n;
  logic [2:0]    tag, tag_n;
  logic [5:0]    result, result_n;
  logic [2:0]    opcode, opcode_n;
  logic          out_valid, out_valid_n;
  logic          ovf, ovf_n;
  logic          udf, udf_n;
  logic          push;
  logic          full, empty;
  logic [8:0]    stack [DEPTH];
  logic [8:0]    top;

  assign exe_ev = bus.execute & ~exe_q;
  assign rd_ev  = bus.read & ~rd_q;
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  // When count==0 the index wraps to DEPTH-1; the value is unused then.
  assign top    = stack[AW'(count - ONE)];

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    count_n     = count;
    rd_pend_n   = rd_pend;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    alu_op_n    = alu_op;
    tag_n       = tag;
    result_n    = result;
    opcode_n    = opcode;
    out_valid_n = 1'b0;
    ovf_n       = ovf;
    udf_n       = udf;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (exe_ev) begin
          // Execute has priority; a coincident read waits in the one-deep slot.
          if (rd_ev) rd_pend_n = 1'b1;
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            alu_a_n  = bus.A;
            alu_b_n  = bus.B;
            alu_op_n = bus.opcodein;
            tag_n    = bus.opcodein;
            wcnt_n   = WAIT_INIT;
            state_n  = WAIT;
          end
        end else if (rd_ev || rd_pend) begin
          rd_pend_n = 1'b0;
          if (empty) begin
            udf_n = 1'b1;
          end else begin
            result_n    = top[5:0];
            opcode_n    = top[8:6];
            count_n     = count - ONE;
            out_valid_n = 1'b1;
          end
        end
      end
      WAIT: begin
        // Executes arriving here are dropped: operands would be stale by issue.
        if (rd_ev) rd_pend_n = 1'b1;
        if (wcnt != 4'd0) begin
          wcnt_n = wcnt - 4'd1;
        end else begin
          push    = 1'b1;
          count_n = count + ONE;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      count     <= '0;
      rd_pend   <= 1'b0;
      // Held high so a level already asserted at release is not an event.
      exe_q     <= 1'b1;
      rd_q      <= 1'b1;
      alu_a     <= 3'd0;
      alu_b     <= 3'd0;
      alu_op    <= 3'd0;
      tag       <= 3'd0;
      result    <= 6'd0;
      opcode    <= 3'd0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      count     <= count_n;
      rd_pend   <= rd_pend_n;
      exe_q     <= bus.execute;
      rd_q      <= bus.read;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      alu_op    <= alu_op_n;
      tag       <= tag_n;
      result    <= result_n;
      opcode    <= opcode_n;
      out_valid <= out_valid_n;
      ovf       <= ovf_n;
      udf       <= udf_n;
    end
  end

  // Stack storage is not reset; a reset during WAIT suppresses the push.
  always_ff @(posedge clk) begin
    if (reset_n && push) stack[AW'(count)] <= {tag, bus.F};
  end

  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  assign bus.alu_op     = alu_op;
  assign bus.result_out = result;
  assign bus.opcode_out = opcode;
  assign bus.out_valid  = out_valid;
  assign bus.count      = count;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.busy       = (state != IDLE);
  assign bus.ovf_err    = ovf;
  assign bus.udf_err    = udf;
endmodule

// File: tb/tb_alu_lifo_ctrl.sv
module tb_alu_lifo_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic reset_n4;
  int   errors = 0;
  int   checks = 0;

  alu_lifo_if #(.DEPTH(DEPTH)) if1 ();
  alu_lifo_if #(.DEPTH(DEPTH)) if4 ();

  alu_lifo_ctrl #(.DEPTH(DEPTH), .ALU_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );
  alu_lifo_ctrl #(.DEPTH(DEPTH), .ALU_LAT(4)) dut4 (
    .clk(clk), .reset_n(reset_n4), .bus(if4.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_alu(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return {3'b0, a & b};
      3'd1:    return {3'b0, a} + {3'b0, b};
      3'd2:    return {3'b0, a} - {3'b0, b};
      3'd3:    return {3'b0, a} * {3'b0, b};
      3'd4:    return {3'b0, a | b};
      3'd5:    return {3'b0, a ^ b};
      3'd6:    return {a, b};
      default: return {3'b0, ~a};
    endcase
  endfunction

  // Single-cycle ALU for dut1, three-register ALU for dut4 (result valid for
  // capture four edges after the operands change).
  assign if1.F = ref_alu(if1.alu_a, if1.alu_b, if1.alu_op);
  logic [5:0] f4_p0, f4_p1, f4_p2;
  always @(posedge clk) begin
    f4_p0 <= ref_alu(if4.alu_a, if4.alu_b, if4.alu_op);
    f4_p1 <= f4_p0;
    f4_p2 <= f4_p1;
  end
  assign if4.F = f4_p2;

  // Reference model of dut1: LIFO of {opcode, result} plus display/flag state.
  logic [8:0] mq[$];
  logic [5:0] m_res;
  logic [2:0] m_op;
  logic [2:0] m_alu_a;
  logic       m_ovf;
  logic       m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(if1.count), mq.size());
    chk({tag, ".full"}, 32'(if1.full), 32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(if1.empty), 32'(mq.size() == 0));
    chk({tag, ".busy"}, 32'(if1.busy), 0);
    chk({tag, ".ovf"}, 32'(if1.ovf_err), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(if1.udf_err), 32'(m_udf));
    chk({tag, ".result"}, 32'(if1.result_out), 32'(m_res));
    chk({tag, ".opcode"}, 32'(if1.opcode_out), 32'(m_op));
  endtask

  task automatic do_reset1();
    reset_n = 1'b0;
    if1.execute = 1'b0;
    if1.read = 1'b0;
    step();
    step();
    chk("rst.count", 32'(if1.count), 0);
    chk("rst.empty", 32'(if1.empty), 1);
    chk("rst.full", 32'(if1.full), 0);
    chk("rst.busy", 32'(if1.busy), 0);
    chk("rst.out_valid", 32'(if1.out_valid), 0);
    chk("rst.result", 32'(if1.result_out), 0);
    chk("rst.opcode", 32'(if1.opcode_out), 0);
    chk("rst.alu", 32'({if1.alu_a, if1.alu_b, if1.alu_op}), 0);
    chk("rst.errs", 32'({if1.ovf_err, if1.udf_err}), 0);
    reset_n = 1'b1;
    step();
    mq.delete();
    m_res = '0;
    m_op = '0;
    m_alu_a = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic do_exec(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    int n;
    if1.A = a;
    if1.B = b;
    if1.opcodein = op;
    if1.execute = 1'b1;
    step();
    if1.execute = 1'b0;
    if (mq.size() < DEPTH) begin
      chk("exe.alu_a", 32'(if1.alu_a), 32'(a));
      chk("exe.alu_b", 32'(if1.alu_b), 32'(b));
      chk("exe.alu_op", 32'(if1.alu_op), 32'(op));
      n = 0;
      for (int i = 0; i < 20 && if1.busy; i++) begin
        n++;
        step();
      end
      chk("exe.busy_cycles", n, 1);
      mq.push_back({op, ref_alu(a, b, op)});
      m_alu_a = a;
    end else begin
      chk("ovf.busy", 32'(if1.busy), 0);
      chk("ovf.alu_a", 32'(if1.alu_a), 32'(m_alu_a));
      m_ovf = 1'b1;
      step();
    end
    check_state("exec");
  endtask

  task automatic do_read();
    logic [8:0] e;
    if1.read = 1'b1;
    step();
    if1.read = 1'b0;
    if (mq.size() > 0) begin
      e = mq.pop_back();
      chk("read.out_valid", 32'(if1.out_valid), 1);
      m_res = e[5:0];
      m_op = e[8:6];
    end else begin
      chk("udf.out_valid", 32'(if1.out_valid), 0);
      m_udf = 1'b1;
    end
    check_state("read");
    step();
    chk("read.out_valid_drop", 32'(if1.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    reset_n4 = 1'b0;
    if1.execute = 1'b0; if1.read = 1'b0;
    if1.A = '0; if1.B = '0; if1.opcodein = '0;
    if4.execute = 1'b0; if4.read = 1'b0;
    if4.A = '0; if4.B = '0; if4.opcodein = '0;

    // Basic execute then pop: 3+2 tagged with opcode 1.
    do_reset1();
    do_exec(3'd3, 3'd2, 3'd1);
    do_read();

    // LIFO ordering 5,6,7 -> 7,6,5.
    do_exec(3'd3, 3'd2, 3'd1);
    do_exec(3'd3, 3'd3, 3'd1);
    do_exec(3'd3, 3'd4, 3'd1);
    repeat (3) do_read();

    // Underflow on empty after reset.
    do_reset1();
    do_read();
    chk("udf.result_zero", 32'(if1.result_out), 0);

    // Fill to DEPTH, overflow attempt, drain.
    do_reset1();
    repeat (DEPTH) do_exec(3'($urandom), 3'($urandom), 3'($urandom));
    do_exec(3'd7, 3'd7, 3'd3);
    repeat (DEPTH) do_read();

    // Simultaneous execute and read with count==1 (top=5), next F=6.
    do_reset1();
    do_exec(3'd3, 3'd2, 3'd1);
    if1.A = 3'd4; if1.B = 3'd2; if1.opcodein = 3'd1;
    if1.execute = 1'b1;
    if1.read = 1'b1;
    step();
    if1.execute = 1'b0;
    if1.read = 1'b0;
    chk("sim.e0_busy", 32'(if1.busy), 1);
    chk("sim.e0_valid", 32'(if1.out_valid), 0);
    step();
    chk("sim.e1_count", 32'(if1.count), 2);
    chk("sim.e1_valid", 32'(if1.out_valid), 0);
    step();
    chk("sim.e2_valid", 32'(if1.out_valid), 1);
    chk("sim.e2_result", 32'(if1.result_out), 6);
    chk("sim.e2_count", 32'(if1.count), 1);
    m_res = 6'd6;
    m_op = 3'd1;
    step();
    chk("sim.e3_valid", 32'(if1.out_valid), 0);
    check_state("sim");

    // Random mix of executes and reads against the model.
    do_reset1();
    repeat (60) begin
      if ($urandom_range(0, 1) == 1) do_exec(3'($urandom), 3'($urandom), 3'($urandom));
      else do_read();
    end

    // ALU_LAT=4: reset during WAIT with execute held high across release.
    step();
    reset_n4 = 1'b1;
    step();
    if4.A = 3'd1; if4.B = 3'd1; if4.opcodein = 3'd1;
    if4.execute = 1'b1;
    step();
    chk("l4.e0_busy", 32'(if4.busy), 1);
    step();
    reset_n4 = 1'b0;
    step();
    chk("l4.rst_busy", 32'(if4.busy), 0);
    chk("l4.rst_count", 32'(if4.count), 0);
    step();
    reset_n4 = 1'b1;
    repeat (6) step();
    chk("l4.held_busy", 32'(if4.busy), 0);
    chk("l4.held_count", 32'(if4.count), 0);
    chk("l4.held_alu_a", 32'(if4.alu_a), 0);
    if4.execute = 1'b0;
    step();
    if4.execute = 1'b1;
    step();
    if4.execute = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && if4.busy; i++) begin
      n++;
      step();
    end
    chk("l4.busy_cycles", n, 4);
    chk("l4.count", 32'(if4.count), 1);
    if4.read = 1'b1;
    step();
    if4.read = 1'b0;
    chk("l4.pop_valid", 32'(if4.out_valid), 1);
    chk("l4.pop_result", 32'(if4.result_out), 32'(ref_alu(3'd1, 3'd1, 3'd1)));
    chk("l4.pop_count", 32'(if4.count), 0);
    step();

    // ALU_LAT=4: read during WAIT is serviced right after the push.
    if4.A = 3'd5; if4.B = 3'd6; if4.opcodein = 3'd0;
    if4.execute = 1'b1;
    step();
    if4.execute = 1'b0;
    if4.read = 1'b1;
    step();
    if4.read = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && !if4.out_valid; i++) begin
      n++;
      step();
    end
    chk("l4.pend_delay", n, 4);
    chk("l4.pend_result", 32'(if4.result_out), 32'(ref_alu(3'd5, 3'd6, 3'd0)));
    chk("l4.pend_opcode", 32'(if4.opcode_out), 0);
    chk("l4.pend_count", 32'(if4.count), 0);
    chk("l4.errs", 32'({if4.ovf_err, if4.udf_err}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_lifo_ctrl.md
# alu_lifo_ctrl

Sequencing controller for the calculator datapath. It turns `execute` and `read` button-style inputs into single events and launches one ALU operation per `execute`. It pushes each 6-bit ALU result, tagged with its 3-bit opcode, onto an internal LIFO stack, and pops the top entry to the display path on `read`. It sits between the board inputs and the ALU / LED display logic, and it owns all ordering between writer (ALU) and reader (display).

## Interface
- `DEPTH`, default 8: stack entries; power of two, range 2..16.
- `ALU_LAT`, default 1: cycles from `alu_a`/`alu_b`/`alu_op` update to valid `F`; range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `execute` in 1: operate request; level input, a rising edge is an event.
- `read` in 1: pop request; level input, a rising edge is an event.
- `A`, `B` in 3 each: live operands.
- `opcodein` in 3: live opcode.
- `F` in 6: ALU result for the `alu_*` outputs.
- `alu_a`, `alu_b`, `alu_op` out 3 each: registered operands/opcode driven to the ALU.
- `result_out` out 6: last popped result; holds until the next pop.
- `opcode_out` out 3: opcode tag of the last popped entry.
- `out_valid` out 1: one-cycle pulse on each successful pop.
- `count` out $clog2(DEPTH+1): current occupancy.
- `full`, `empty` out 1: `count==DEPTH`, `count==0`; both combinational from `count`.
- `busy` out 1: high while state≠IDLE.
- `ovf_err`, `udf_err` out 1: sticky error flags, cleared only by reset.

## Operation
- Edge detect: `exe_q`/`rd_q` register the inputs every cycle.
  - `exe_ev = execute & ~exe_q`; `rd_ev = read & ~rd_q`.
- States:
  - IDLE
  - WAIT, with down-counter `wcnt`.
- IDLE, `exe_ev`, not full:
  - load `alu_a<=A`, `alu_b<=B`, `alu_op<=opcodein`, `tag<=opcodein`
  - `wcnt<=ALU_LAT-1`, go to WAIT.
- IDLE, `exe_ev`, full: set `ovf_err`; no operand load; stay in IDLE.
- WAIT:
  - `wcnt!=0`: decrement.
  - `wcnt==0`: write {`tag`,`F`} to `stack[count]`, `count+1`, go to IDLE.
- Pop (IDLE only, no `exe_ev` this cycle), triggered by `rd_ev` or `rd_pend`, stack not empty:
  - `result_out`/`opcode_out <= stack[count-1]`
  - `count-1`, `out_valid<=1`, clear `rd_pend`.
- Pop trigger with stack empty: set `udf_err`; outputs unchanged; clear `rd_pend`.
- Arbitration:
  - `exe_ev` and `rd_ev` in the same IDLE cycle: execute wins; the read is held in `rd_pend`.
  - `rd_ev` during WAIT sets `rd_pend`.
  - `rd_pend` is one deep; a further `rd_ev` while it is set is dropped.
- `exe_ev` during WAIT is dropped, not queued, because a deferred issue would sample stale operands. `busy` tells upstream logic this.
- Pending read is serviced on the first IDLE cycle after the push, where `exe_ev` again takes priority.
- Stack RAM is not cleared by reset; entries at index ≥`count` are don't-care.

## Timing
- Reset (any cycle, including mid-WAIT):
  - state IDLE, `count=0`, `rd_pend=0`, `wcnt=0`
  - all outputs 0, except `empty=1`
  - `exe_q=rd_q=1`, so an input held high through reset release makes no event until it falls and rises again.
  - Any in-flight operation is discarded without a push.
- Execute latency (`exe_ev` sampled at edge E0):
  - `alu_*` valid after E0.
  - `F` captured at edge E0+`ALU_LAT`.
  - `count` updates after that edge.
  - `busy` high for exactly `ALU_LAT` cycles.
- Read latency: `rd_ev` sampled at edge E0 in IDLE gives `result_out`, `opcode_out`, `count` and `out_valid` updated after E0. `out_valid` is high for exactly one cycle.
- Back-to-back: one push or one pop per edge at most; never both on the same edge.
- `count` never exceeds `DEPTH` and never underflows.

## Test plan
- Reset, then `A=3 B=2 opcodein=1`, ALU model F=A+B, pulse `execute`:
  - `alu_a=3` after E0
  - `busy` for 1 cycle
  - `count=1`, `empty=0` after E1
  - popped entry gives `result_out=5`, `opcode_out=1`.
- Push F=5,6,7, then three `read` pulses → `result_out` 7,6,5, each with a one-cycle `out_valid`; `empty=1` after the third.
- Fill 8 entries, 9th `execute`:
  - `ovf_err=1`, `count=8`, `full=1`
  - `alu_a` unchanged, `busy` stays 0.
- `read` on empty after reset → `udf_err=1`, `out_valid` never high, `result_out=0`.
- `count=1` (top=5), `execute` and `read` rise on the same edge with next F=6:
  - push at E1
  - pop at E2 gives `result_out=6`, `count=1`.
- `reset_n` low during WAIT with `ALU_LAT=4`, `execute` held high across release:
  - `count=0`, `busy=0`, no push
  - no event until `execute` toggles low then high.
